// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and entry type for the writeback history buffer
package wb_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_AW       = 5;

    typedef struct packed {
        logic                    valid;
        logic [REG_AW-1:0]       rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - priority match of one lookup address over the history entries
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][REG_AW-1:0] rd,
    input  logic [DEPTH-1:0][XLEN-1:0]   data,
    input  logic [REG_AW-1:0]            rs_addr,
    output logic                         hit,
    output logic [XLEN-1:0]              rs_data
);

    // Scan oldest to newest so the newest matching entry is the one left standing.
    always_comb begin
        hit     = 1'b0;
        rs_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && (rd[i] == rs_addr) && (rs_addr != '0)) begin
                hit     = 1'b1;
                rs_data = data[i];
            end
        end
    end

endmodule

// File: rtl/wb_history_buf.sv
// rtl/wb_history_buf.sv - shift register of recent register writes with forwarding lookups
module wb_history_buf
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2,
    parameter int NRD   = 2,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         adv,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [REG_AW-1:0]            wr_rd,
    input  logic [XLEN-1:0]              wr_data,
    input  logic [NRD-1:0][REG_AW-1:0]   rs_addr,
    output logic [NRD-1:0]               rs_hit,
    output logic [NRD-1:0][XLEN-1:0]     rs_data,
    output logic [OCC_W-1:0]             occ
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][XLEN-1:0]   data_q, data_d;
    logic [OCC_W-1:0]             occ_q, occ_d;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
        end else if (adv) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_d[i] = valid_q[i-1];
                rd_d[i]    = rd_q[i-1];
                data_d[i]  = data_q[i-1];
            end
            // Writes to x0 are recorded but never marked valid.
            valid_d[0] = wr_en && (wr_rd != '0);
            rd_d[0]    = wr_rd;
            data_d[0]  = wr_data;
        end
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            occ_q   <= occ_d;
        end
    end

    assign occ = occ_q;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        wb_fwd_match #(
            .XLEN  (XLEN),
            .DEPTH (DEPTH)
        ) u_match (
            .valid   (valid_q),
            .rd      (rd_q),
            .data    (data_q),
            .rs_addr (rs_addr[p]),
            .hit     (rs_hit[p]),
            .rs_data (rs_data[p])
        );
    end

endmodule

// File: doc/wb_history_buf.md
WB_HISTORY_BUF -- requirements
Module: wb_history_buf

Interface
REQ-001 Parameter XLEN, default 32, data width of a writeback value.
REQ-002 Parameter DEPTH, default 2, number of history entries (1..8).
REQ-003 Parameter NRD, default 2, number of forwarding lookup ports (1..4).
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 adv  in  1  advance enable; low = hold the history (pipeline stall).
REQ-007 flush  in  1  invalidate all history entries.
REQ-008 wr_en  in  1  MW-stage register-write enable.
REQ-009 wr_rd  in  5  MW-stage destination register index.
REQ-010 wr_data  in  XLEN  value written to the register file this cycle.
REQ-011 rs_addr  in  NRD x 5  lookup source register indices.
REQ-012 rs_hit  out  NRD  lookup port n matches a valid history entry.
REQ-013 rs_data  out  NRD x XLEN  forwarded value for port n; zero when no hit.
REQ-014 occ  out  clog2(DEPTH+1)  number of valid entries.

Function
REQ-015 Storage: DEPTH entries {valid, rd, data}; entry 0 newest, entry DEPTH-1 oldest.
REQ-016 Push: adv=1, flush=0 -> entries shift one toward oldest, and the oldest entry is discarded.
REQ-017 Push loads entry 0 with valid = wr_en AND (wr_rd != 0), rd = wr_rd, data = wr_data.
REQ-018 adv=0, flush=0 -> every entry holds, including entry 0; wr_* is ignored.
REQ-019 flush=1 -> all valid bits cleared on that edge regardless of adv; the simultaneous push is dropped.
REQ-020 Lookup is combinational from registered entries only; there is no bypass of the same-cycle wr_* inputs.
REQ-021 Latency: a write pushed at edge N is visible to lookups from edge N until DEPTH further pushes or a flush.
REQ-022 Port n hits when any valid entry has rd == rs_addr[n]; rs_addr[n]=0 never hits.
REQ-023 Multiple matches -> data of the newest matching entry (lowest index) is returned.
REQ-024 Ports are independent; identical addresses on several ports return identical results.
REQ-025 rs_data[n] = 0 whenever rs_hit[n] = 0.
REQ-026 occ = count of valid bits, 0..DEPTH, updated with the entries; it saturates naturally at DEPTH because the oldest entry drops out.
REQ-027 DEPTH=1 degenerates to a single writeback register with valid qualification.

Reset
REQ-028 rst_n low -> all valid bits 0, rd 0, data 0, occ 0, immediately and without waiting for clk.
REQ-029 Outputs during reset: rs_hit all 0, rs_data all 0.
REQ-030 Reset deassertion -> the first push occurs at the first rising edge where rst_n=1 and adv=1.
REQ-031 Reset asserted mid-stall or mid-flush overrides both.

Structure
REQ-032 Shared package wb_pkg holds XLEN default, REG_AW=5, and the wb_entry_t struct {valid, rd, data}.
REQ-033 Sub-module wb_fwd_match, one per lookup port: a priority match over the entry array, returning {hit, data}.
REQ-034 The top holds the entry register array and occ; it contains no latches.

Verification
REQ-035 Push rd=5,data=0xAAAA_0001, then push rd=5,data=0xBBBB_0002; lookup rs=5 -> hit=1, data=0xBBBB_0002, occ=2.
REQ-036 DEPTH=2: push rd=3, rd=4, rd=6 -> lookup rs=3 gives hit=0, and lookup rs=4 gives hit=1.
REQ-037 Push rd=7,data=0x1234 with adv=0 for 3 cycles -> no entry changes; a later adv=1 pushes the current wr_*.
REQ-038 Push with wr_en=1, wr_rd=0 -> entry 0 invalid, rs=0 lookup hit=0, occ unchanged except for the oldest entry dropping.
REQ-039 flush=1 and adv=1 with wr_rd=9 on the same edge -> occ=0 and all rs_hit=0 on the next cycle.
REQ-040 Assert rst_n=0 between edges with occ=2 -> occ=0 and rs_hit=0 before the next clk edge.
